// File: rtl/module_switch_pkg.sv
// Shared types and constants for the switch debounce path.
package module_switch_pkg;

    // Debounce FSM: IDLE holds the accepted level, COUNT times a stability window.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } db_state_t;

    // 10 ms at 27 MHz.
    localparam int DB_CYCLES_DEFAULT = 270000;

    // Short window used by simulation so scenarios stay a few dozen cycles long.
    localparam int SIM_DB_CYCLES = 8;

endpackage

// File: rtl/module_sync_2ff.sv
// Two-flop synchronizer for asynchronous pin inputs, one flop pair per bit.
// The bits are not coherent across the vector; downstream debouncing is
// expected to absorb skew between bits.
module module_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the settled output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/module_switch_debounce.sv
// Switch/button input path: synchronize, debounce the whole vector as one,
// hold the stable level and report each accepted change as an event.
//
// Event handshake: evt_valid is a registered level that rises when a new
// level is accepted and stays high until a cycle where evt_valid && evt_ready
// (a transfer). evt_data/evt_mask are stable while evt_valid is high unless a
// newer event overwrites them: evt_data takes the newest level and evt_mask
// accumulates changed bits until the consumer takes the event.
//
// Optional feature: define MODULE_SWITCH_OVERRUN_EN to get the `overrun`
// output, a one-cycle pulse when an event overwrites an untaken one.
module module_switch_debounce
    import module_switch_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] sw_q,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    output logic [WIDTH-1:0] evt_mask
`ifdef MODULE_SWITCH_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    localparam int              CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    db_state_t        state, state_nxt;
    logic             window_done;
    logic             raise;
    logic             transfer;
    logic             pending;

    logic [WIDTH-1:0] sw_q_nxt;
    logic             evt_valid_nxt;
    logic [WIDTH-1:0] evt_data_nxt;
    logic [WIDTH-1:0] evt_mask_nxt;

    module_sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_in),
        .q     (s)
    );

    // FSM state, candidate level and window counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Any movement of the synchronized vector restarts the full window;
    // a window that runs out unchanged accepts the candidate.
    always_comb begin
        state_nxt   = state;
        cand_nxt    = cand;
        cnt_nxt     = cnt;
        window_done = 1'b0;
        if (s != cand) begin
            cand_nxt  = s;
            cnt_nxt   = '0;
            state_nxt = COUNT;
        end else if (state == COUNT) begin
            if (cnt == CNT_LAST) begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                window_done = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // A window that settles back on the held level is a bounce: no event.
    assign raise    = window_done && (cand != sw_q);
    assign transfer = evt_valid && evt_ready;
    assign pending  = evt_valid && !evt_ready;

    // Next stable level and event slot: a new event wins over a transfer on
    // the same edge, and only accumulates the mask when the old one stays.
    always_comb begin
        sw_q_nxt      = sw_q;
        evt_valid_nxt = evt_valid;
        evt_data_nxt  = evt_data;
        evt_mask_nxt  = evt_mask;
        if (raise) begin
            sw_q_nxt      = cand;
            evt_valid_nxt = 1'b1;
            evt_data_nxt  = cand;
            evt_mask_nxt  = (pending ? evt_mask : '0) | (sw_q ^ cand);
        end else if (transfer) begin
            evt_valid_nxt = 1'b0;
            evt_mask_nxt  = '0;
        end
    end

    // Stable level and event registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q      <= '0;
            evt_valid <= 1'b0;
            evt_data  <= '0;
            evt_mask  <= '0;
        end else begin
            sw_q      <= sw_q_nxt;
            evt_valid <= evt_valid_nxt;
            evt_data  <= evt_data_nxt;
            evt_mask  <= evt_mask_nxt;
        end
    end

`ifdef MODULE_SWITCH_OVERRUN_EN
    // Flag an event that replaced one the consumer never took.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= raise && pending;
        end
    end
`endif

endmodule

// File: tb/tb_module_switch_debounce.sv
// Bench for module_switch_debounce with the short simulation window.
// Builds with or without MODULE_SWITCH_OVERRUN_EN.
module tb_module_switch_debounce;
    import module_switch_pkg::*;

    localparam int W  = 4;
    localparam int DB = SIM_DB_CYCLES;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_in = '0;
    logic         evt_ready = 1'b0;
    logic [W-1:0] sw_q;
    logic         evt_valid;
    logic [W-1:0] evt_data;
    logic [W-1:0] evt_mask;
`ifdef MODULE_SWITCH_OVERRUN_EN
    logic         overrun;
`endif

    initial forever #5 clk = ~clk;

    module_switch_debounce #(
        .WIDTH     (W),
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .evt_ready (evt_ready),
        .sw_q      (sw_q),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_mask  (evt_mask)
`ifdef MODULE_SWITCH_OVERRUN_EN
        ,
        .overrun   (overrun)
`endif
    );

    // ---------------- reference model ----------------
    // The model sees the synchronized input as sw_in delayed by two edges,
    // and accepts a level once it has been seen unchanged on DB+1 edges
    // in a row, counting from the edge on which it first differed.
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] sw_pipe[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_last_seen;
    int           m_run;
    bit           m_armed;
    logic [W-1:0] m_sw_q, m_data, m_mask;
    logic         m_valid, m_ovr;
    logic [W-1:0] obs_data;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        sw_pipe = {};
        sw_pipe.push_back('0);
        sw_pipe.push_back('0);
        exp_q = {};
        m_last_seen = '0;
        m_run = 0;
        m_armed = 1'b0;
        m_sw_q = '0;
        m_data = '0;
        m_mask = '0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
    endtask

    // Advance the model over one rising edge using the inputs present before it.
    task automatic model_edge();
        logic [W-1:0] x;
        bit           accept;
        bit           raise;
        bit           xfer;
        bit           keep;
        logic [W-1:0] got;
        if (!rst_n) begin
            model_reset();
            return;
        end
        x = sw_pipe.pop_front();
        sw_pipe.push_back(sw_in);
        accept = 1'b0;
        if (x != m_last_seen) begin
            m_last_seen = x;
            m_run = 1;
            m_armed = 1'b1;
        end else if (m_armed) begin
            m_run++;
            if (m_run == DB + 1) begin
                accept = 1'b1;
                m_armed = 1'b0;
            end
        end
        raise = accept && (x != m_sw_q);
        xfer  = m_valid && evt_ready;
        keep  = m_valid && !evt_ready;
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 16'(exp_q.size()), 16'd1);
            end else begin
                got = exp_q.pop_front();
                check("sb_delivered", 16'(obs_data), 16'(got));
            end
        end
        m_ovr = raise && keep;
        if (raise) begin
            if (keep && exp_q.size() != 0) void'(exp_q.pop_back());
            exp_q.push_back(x);
            m_mask  = (keep ? m_mask : '0) | (m_sw_q ^ x);
            m_data  = x;
            m_valid = 1'b1;
            m_sw_q  = x;
        end else if (xfer) begin
            m_valid = 1'b0;
            m_mask  = '0;
        end
    endtask

    task automatic compare_all();
        check("sw_q", 16'(sw_q), 16'(m_sw_q));
        check("evt_valid", 16'(evt_valid), 16'(m_valid));
        check("evt_data", 16'(evt_data), 16'(m_data));
        check("evt_mask", 16'(evt_mask), 16'(m_mask));
`ifdef MODULE_SWITCH_OVERRUN_EN
        check("overrun", 16'(overrun), 16'(m_ovr));
`endif
        obs_data = evt_data;
    endtask

    // ---------------- driver tasks ----------------
    // One rising edge, then outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- directed + random sequence ----------------
    int           changes;
    int           valid_cycles;
    int           ovr_pulses;
    int           change_at;
    int           seen_at;
    logic [W-1:0] prev_q;

    initial begin
        model_reset();
        @(negedge clk);
        step_n(2);
        rst_n = 1'b1;

        // Reset then idle.
        check("reset_sw_q", 16'(sw_q), 16'h0);
        check("reset_valid", 16'(evt_valid), 16'h0);
        valid_cycles = 0;
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (evt_valid) valid_cycles++;
            if (sw_q != 4'b0000) changes++;
        end
        check("idle_valid_cycles", 16'(valid_cycles), 16'd0);
        check("idle_sw_q_nonzero", 16'(changes), 16'd0);

        // Clean step: value driven before edge k, accepted at edge k+10.
        sw_in = 4'b0101;
        step_n(10);
        check("step_before_window", 16'(sw_q), 16'h0);
        step();
        check("step_sw_q", 16'(sw_q), 16'h5);
        check("step_valid", 16'(evt_valid), 16'h1);
        check("step_data", 16'(evt_data), 16'h5);
        check("step_mask", 16'(evt_mask), 16'h5);
        evt_ready = 1'b1;
        step();
        check("step_valid_after_xfer", 16'(evt_valid), 16'h0);

        // Back to 0000 so the bounce starts from a known level.
        sw_in = 4'b0000;
        step_n(14);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold 0001.
        changes = 0;
        valid_cycles = 0;
        change_at = -1;
        for (int i = 0; i < 30; i++) begin
            sw_in = ((i / 3) % 2 == 0) ? 4'b0001 : 4'b0000;
            prev_q = sw_q;
            step();
            if (sw_q !== prev_q) changes++;
            if (evt_valid) valid_cycles++;
        end
        sw_in = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            prev_q = sw_q;
            step();
            if (sw_q !== prev_q) begin
                changes++;
                change_at = i;
            end
            if (evt_valid) valid_cycles++;
        end
        check("bounce_changes", 16'(changes), 16'd1);
        check("bounce_events", 16'(valid_cycles), 16'd1);
        // Final toggle lands before edge k; the 11th step is edge k+10.
        check("bounce_latency", 16'(change_at), 16'd11);

        // Return to 0000, then a 5-cycle glitch to 1000.
        sw_in = 4'b0000;
        step_n(14);
        changes = 0;
        valid_cycles = 0;
        sw_in = 4'b1000;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) sw_in = 4'b0000;
            prev_q = sw_q;
            step();
            if (sw_q !== prev_q) changes++;
            if (evt_valid) valid_cycles++;
        end
        check("glitch_changes", 16'(changes), 16'd0);
        check("glitch_events", 16'(valid_cycles), 16'd0);

        // Overwrite with the consumer stalled.
        evt_ready = 1'b0;
        ovr_pulses = 0;
        sw_in = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            step();
`ifdef MODULE_SWITCH_OVERRUN_EN
            if (overrun) ovr_pulses++;
`endif
        end
        sw_in = 4'b0011;
        for (int i = 0; i < 14; i++) begin
            step();
`ifdef MODULE_SWITCH_OVERRUN_EN
            if (overrun) ovr_pulses++;
`endif
        end
        check("ovw_valid", 16'(evt_valid), 16'h1);
        check("ovw_data", 16'(evt_data), 16'h3);
        check("ovw_mask", 16'(evt_mask), 16'h3);
`ifdef MODULE_SWITCH_OVERRUN_EN
        check("ovw_overrun_pulses", 16'(ovr_pulses), 16'd1);
`endif

        // Reset 4 cycles into COUNT while the overwritten event is pending.
        sw_in = 4'b0110;
        step_n(6);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_sw_q", 16'(sw_q), 16'h0);
        check("rst_valid", 16'(evt_valid), 16'h0);
        check("rst_data", 16'(evt_data), 16'h0);
        check("rst_mask", 16'(evt_mask), 16'h0);
        compare_all();
        step_n(3);
        rst_n = 1'b1;
        seen_at = 99;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (evt_valid && seen_at == 99) seen_at = i;
        end
        // First edge after release is k; the event lands on edge k+10.
        check("rst_event_latency", 16'(seen_at), 16'd11);
        check("rst_event_data", 16'(evt_data), 16'h6);

        // Randomized holds with a randomly stalling consumer.
        for (int seg = 0; seg < 70; seg++) begin
            sw_in = 4'($urandom_range(0, 15));
            for (int h = $urandom_range(1, 14); h > 0; h--) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        // Let the last level settle and drain.
        evt_ready = 1'b1;
        step_n(15);
        check("drain_valid", 16'(evt_valid), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a wait ever runs away.
    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
